// File: rtl/usi_dma_pkg.sv
// rtl/usi_dma_pkg.sv - shared state encoding and width helper for the USI DMA request scheduler
package usi_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic int sw_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usi_dma_req_sched_if.sv
// rtl/usi_dma_req_sched_if.sv - USI request lines and DMA channel handshake bundle
interface usi_dma_req_sched_if
  import usi_dma_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int SW = sw_width(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_trust;
  logic [NUM_REQ-1:0] req_ack;
  logic               dma_req;
  logic [SW-1:0]      dma_src;
  logic               dma_sec;
  logic               dma_ack;

  modport master (
    output req, req_trust, dma_ack,
    input  req_ack, dma_req, dma_src, dma_sec
  );

  modport slave (
    input  req, req_trust, dma_ack,
    output req_ack, dma_req, dma_src, dma_sec
  );

endinterface

// File: rtl/usi_rr_pick.sv
// rtl/usi_rr_pick.sv - round-robin picker: first set bit of vec scanning upward from ptr+1 with wrap
module usi_rr_pick
  import usi_dma_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int SW      = sw_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_vec,
  input  logic [SW-1:0]      i_ptr,
  output logic               o_valid,
  output logic [SW-1:0]      o_idx
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  int                   w_start;
  int                   w_off;
  int                   w_sum;

  // Doubling the vector turns the wrap-around rotate into a plain right shift.
  always_comb begin
    w_dbl   = {i_vec, i_vec};
    w_start = int'(i_ptr) + 1;
    w_rot   = NUM_REQ'(w_dbl >> w_start);
    w_off   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i;
    end
    w_sum = w_start + w_off;
    if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
    o_valid = |i_vec;
    o_idx   = SW'(w_sum);
  end

endmodule

// File: rtl/usi_dma_req_sched.sv
// rtl/usi_dma_req_sched.sv - round-robin scheduler sharing one DMA channel among USI rx/tx request lines
module usi_dma_req_sched
  import usi_dma_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 255,
  localparam int SW      = sw_width(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_chan_en,
  input  logic                 i_sec_only,
  usi_dma_req_sched_if.slave   bus,
  output logic                 o_busy,
  output logic                 o_timeout_err
);

  localparam int            CW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e             r_state, w_state_nxt;
  logic [SW-1:0]      r_grant, w_grant_nxt;
  logic [SW-1:0]      r_ptr, w_ptr_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_dma_req, w_dma_req_nxt;
  logic               r_dma_sec, w_dma_sec_nxt;
  logic [NUM_REQ-1:0] r_req_ack, w_req_ack_nxt;
  logic               r_tmo, w_tmo_nxt;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_pick_valid;
  logic [SW-1:0]      w_pick_idx;

  assign w_elig = bus.req & (i_sec_only ? bus.req_trust : {NUM_REQ{1'b1}}) & {NUM_REQ{i_chan_en}};

  usi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_vec   (w_elig),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_dma_req_nxt = r_dma_req;
    w_dma_sec_nxt = r_dma_sec;
    w_req_ack_nxt = '0;
    w_tmo_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        w_dma_req_nxt = 1'b0;
        w_dma_sec_nxt = 1'b0;
        if (w_pick_valid) begin
          w_state_nxt   = REQ;
          w_grant_nxt   = w_pick_idx;
          w_ptr_nxt     = w_pick_idx;
          w_cnt_nxt     = '0;
          w_dma_req_nxt = 1'b1;
          w_dma_sec_nxt = bus.req_trust[w_pick_idx];
        end
      end
      REQ: begin
        if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
        // Ack outranks a same-cycle withdrawal: the data already moved.
        if (bus.dma_ack) begin
          w_req_ack_nxt[r_grant] = 1'b1;
          w_dma_req_nxt          = 1'b0;
          w_dma_sec_nxt          = 1'b0;
          w_state_nxt            = GAP;
        end else if (!bus.req[r_grant]) begin
          w_dma_req_nxt = 1'b0;
          w_dma_sec_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_tmo_nxt     = 1'b1;
          w_dma_req_nxt = 1'b0;
          w_dma_sec_nxt = 1'b0;
          w_state_nxt   = GAP;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_dma_req_nxt = 1'b0;
        w_dma_sec_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= SW'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_dma_req <= 1'b0;
      r_dma_sec <= 1'b0;
      r_req_ack <= '0;
      r_tmo     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dma_req <= w_dma_req_nxt;
      r_dma_sec <= w_dma_sec_nxt;
      r_req_ack <= w_req_ack_nxt;
      r_tmo     <= w_tmo_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign bus.dma_req    = r_dma_req;
  assign bus.dma_src    = r_grant;
  assign bus.dma_sec    = r_dma_sec;
  assign bus.req_ack    = r_req_ack;
  assign o_busy         = r_busy;
  assign o_timeout_err  = r_tmo;

endmodule

// File: tb/tb_usi_dma_req_sched.sv
// tb/tb_usi_dma_req_sched.sv - directed self-checking bench for usi_dma_req_sched
module tb_usi_dma_req_sched;

  logic clk = 1'b0;
  logic rst;
  logic chan_en;
  logic sec_only;
  logic busy;
  logic timeout_err;
  int   n_pass = 0;
  int   n_total = 0;

  usi_dma_req_sched_if #(.NUM_REQ(4)) bus ();

  usi_dma_req_sched #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_chan_en     (chan_en),
    .i_sec_only    (sec_only),
    .bus           (bus),
    .o_busy        (busy),
    .o_timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait for a grant, check it, ack after ack_wait REQ cycles, optionally drop the level request.
  task automatic xfer(input int idx, input logic sec, input int ack_wait, input logic drop);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.dma_req && n < 10);
    check_eq("grant_latency", n, 1);
    check_eq("grant_src", bus.dma_src, idx);
    check_eq("grant_sec", bus.dma_sec, sec);
    check_eq("grant_busy", busy, 1);
    repeat (ack_wait - 1) tick();
    bus.dma_ack = 1'b1;
    tick();
    bus.dma_ack = 1'b0;
    check_eq("ack_pulse", bus.req_ack, 4'b0001 << idx);
    check_eq("ack_dma_req_low", bus.dma_req, 0);
    if (drop) bus.req[idx] = 1'b0;
    tick();
    check_eq("gap_ack_clear", bus.req_ack, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    chan_en = 1'b0;
    sec_only = 1'b0;
    bus.req = '0;
    bus.req_trust = '0;
    bus.dma_ack = 1'b0;
    do_reset();
    check_eq("rst_dma_req", bus.dma_req, 0);
    check_eq("rst_req_ack", bus.req_ack, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tmo", timeout_err, 0);
    check_eq("rst_src", bus.dma_src, 0);
    check_eq("rst_sec", bus.dma_sec, 0);

    // 1: two requesters, released after each ack
    chan_en = 1'b1;
    bus.req = 4'b0101;
    xfer(0, 1'b0, 1, 1'b1);
    xfer(2, 1'b0, 1, 1'b1);

    // 2: all requesting, strict rotation from reset
    do_reset();
    bus.req = 4'b1111;
    xfer(0, 1'b0, 2, 1'b0);
    xfer(1, 1'b0, 2, 1'b0);
    xfer(2, 1'b0, 2, 1'b0);
    xfer(3, 1'b0, 2, 1'b0);
    xfer(0, 1'b0, 2, 1'b0);

    // 3: secure-only filtering
    do_reset();
    sec_only = 1'b1;
    bus.req = 4'b0011;
    bus.req_trust = 4'b0010;
    xfer(1, 1'b1, 1, 1'b0);
    xfer(1, 1'b1, 1, 1'b1);
    tick();
    tick();
    check_eq("sec_untrusted_dma_req", bus.dma_req, 0);
    check_eq("sec_untrusted_busy", busy, 0);
    sec_only = 1'b0;
    xfer(0, 1'b0, 1, 1'b1);

    // 4: handshake timeout at 8 cycles
    do_reset();
    bus.req_trust = 4'b0000;
    bus.req = 4'b0010;
    tick();
    check_eq("tmo_grant", bus.dma_req, 1);
    check_eq("tmo_src", bus.dma_src, 1);
    n = 1;
    tick();
    while (bus.dma_req && n < 20) begin
      n++;
      tick();
    end
    check_eq("tmo_high_cycles", n, 8);
    check_eq("tmo_pulse", timeout_err, 1);
    check_eq("tmo_no_ack", bus.req_ack, 0);
    tick();
    check_eq("tmo_pulse_end", timeout_err, 0);
    check_eq("tmo_gap_dma_req", bus.dma_req, 0);
    tick();
    check_eq("tmo_regrant", bus.dma_req, 1);
    check_eq("tmo_regrant_src", bus.dma_src, 1);
    bus.req = 4'b0000;
    tick();
    check_eq("wd_dma_req", bus.dma_req, 0);
    check_eq("wd_busy", busy, 0);

    // 5: withdrawal, then withdrawal racing an ack
    do_reset();
    bus.req = 4'b1000;
    tick();
    check_eq("wd3_grant_src", bus.dma_src, 3);
    tick();
    bus.req = 4'b0000;
    tick();
    check_eq("wd3_dma_req", bus.dma_req, 0);
    check_eq("wd3_no_ack", bus.req_ack, 0);
    check_eq("wd3_idle", busy, 0);
    bus.req = 4'b1000;
    tick();
    check_eq("race_grant", bus.dma_req, 1);
    tick();
    bus.req = 4'b0000;
    bus.dma_ack = 1'b1;
    tick();
    bus.dma_ack = 1'b0;
    check_eq("race_ack", bus.req_ack, 4'b1000);
    check_eq("race_gap_busy", busy, 1);
    tick();
    check_eq("race_ack_clear", bus.req_ack, 0);

    // 6: reset in the middle of a handshake restores the pointer
    do_reset();
    bus.req = 4'b1001;
    xfer(0, 1'b0, 1, 1'b0);
    tick();
    check_eq("rst6_grant3", bus.dma_src, 3);
    rst = 1'b1;
    bus.dma_ack = 1'b1;
    tick();
    check_eq("rst6_dma_req", bus.dma_req, 0);
    check_eq("rst6_req_ack", bus.req_ack, 0);
    check_eq("rst6_busy", busy, 0);
    check_eq("rst6_src", bus.dma_src, 0);
    rst = 1'b0;
    bus.dma_ack = 1'b0;
    tick();
    check_eq("rst6_regrant", bus.dma_req, 1);
    check_eq("rst6_regrant_src", bus.dma_src, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
